frame_copy_ctrl: RTL and testbench
==================================

FRAME_COPY_CTRL -- requirements
Module: frame_copy_ctrl

Interface
REQ-001 Parameter ADDR_W, default 19, SHALL set the width of all address and length ports.
REQ-002 Parameter DATA_W, default 8, SHALL set the pixel width.
REQ-003 clk  input  1  SHALL be the single clock; all logic on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 start  input  1  SHALL be the copy request, sampled only in IDLE or DONE.
REQ-006 src_base  input  ADDR_W  SHALL be the first ROM address, captured on the start cycle.
REQ-007 dst_base  input  ADDR_W  SHALL be the first RAM address, captured on the start cycle.
REQ-008 length  input  ADDR_W  SHALL be the pixel count, captured on the start cycle.
REQ-009 hold  input  1  SHALL mean the RAM write port is claimed by another requester: stall.
REQ-010 rom_addr  output  ADDR_W  SHALL be the registered ROM read address.
REQ-011 rom_data  input  DATA_W  SHALL be the ROM data for the rom_addr of the previous cycle.
REQ-012 ram_wraddr  output  ADDR_W  SHALL be the registered RAM write address.
REQ-013 ram_data  output  DATA_W  SHALL be the registered RAM write data.
REQ-014 ram_wren  output  1  SHALL be the registered RAM write enable.
REQ-015 busy  output  1  SHALL be high while a copy is in progress.
REQ-016 done  output  1  SHALL be a level held high from completion until the next accepted start.
REQ-017 checksum  output  16  SHALL carry the copy checksum (see Configuration).

Function
REQ-018 The FSM SHALL have states IDLE, READ, WRITE and DONE; the reset state SHALL be IDLE.
REQ-019 IDLE/DONE -> READ on start with length>0: capture the bases, clear the index, drive rom_addr=src_base, set busy=1, clear done.
REQ-020 IDLE/DONE with start and length=0 SHALL go to DONE with done=1 in the next cycle, no write, busy never high.
REQ-021 READ -> WRITE: ram_data=rom_data, ram_wraddr=dst_base+i, ram_wren=1 for exactly one cycle.
REQ-022 WRITE SHALL advance rom_addr to src_base+i+1 and return to READ, or go to DONE after index length-1.
REQ-023 Throughput SHALL be one pixel per two cycles. With no hold, start sampled at cycle 0 gives writes at cycles 2,4,...,2N, and busy=0 with done=1 from cycle 2N+1.
REQ-024 Address arithmetic SHALL wrap modulo 2^ADDR_W for both src and dst.
REQ-025 hold=1 sampled in READ SHALL keep the FSM in READ, with rom_addr frozen and ram_wren=0 the next cycle. The write SHALL proceed on the first cycle hold is sampled 0.
REQ-026 ram_wren SHALL never be high in a cycle following a cycle with hold=1.
REQ-027 Each index 0..length-1 SHALL be written exactly once, in ascending order, regardless of the hold pattern.
REQ-028 start while busy SHALL be ignored; the captured src_base, dst_base and length SHALL not change mid-copy.
REQ-029 ram_wraddr and ram_data SHALL hold their last values when ram_wren=0.

Reset
REQ-030 reset SHALL force IDLE with rom_addr=0, ram_wraddr=0, ram_data=0, ram_wren=0, busy=0, done=0, checksum=0, index=0.
REQ-031 reset asserted mid-copy SHALL abandon the copy. ram_wren SHALL be 0 from the next cycle and no further write SHALL occur until a new start.
REQ-032 reset SHALL take priority over start and hold in the same cycle.

Configuration
REQ-033 Macro FRAME_COPY_CHECKSUM_EN defined: checksum SHALL be the 16-bit wrap-around sum of all ram_data values written by the current copy. It SHALL be cleared on accepted start and valid when done=1.
REQ-034 FRAME_COPY_CHECKSUM_EN undefined: checksum SHALL be constant 0, and no adder logic SHALL be synthesised.

Verification
REQ-035 Normal copy: src_base=0, dst_base=0, length=19200, ROM data = addr[7:0], hold=0. Expect 19200 writes with RAM[k]=k[7:0]. done=1 at cycle 38401; busy low.
REQ-036 Offset/wrap: src_base=0x7FFFE, dst_base=0x7FFFF, length=4. Expect writes to RAM addresses 0x7FFFF, 0, 1, 2 with data from ROM 0x7FFFE, 0x7FFFF, 0, 1.
REQ-037 Hold: length=8 with hold high for 5 cycles mid-copy. Expect no ram_wren after any hold=1 cycle, 8 writes in order and no duplicates, and done delayed by 5 cycles.
REQ-038 Corner inputs: length=0 -> done=1 next cycle, zero writes. start pulsed mid-copy -> ignored, no change to the write sequence.
REQ-039 Reset mid-copy at the 10th write of length=100. Expect all outputs at reset values the next cycle and no writes until a new start, which then copies 100 pixels correctly.
REQ-040 With FRAME_COPY_CHECKSUM_EN defined: length=4, data 0xFF,0xFF,0x02,0x03 -> checksum=0x0203. Without the macro -> checksum=0.

Source files
------------

// File: rtl/frame_copy_ctrl.sv
// frame_copy_ctrl: copies a block of pixels from a ROM into a RAM, one pixel
// every two clocks. The RAM write port can be stalled by a shared-bus hold.
// Optional feature: define FRAME_COPY_CHECKSUM_EN to get a 16-bit
// wrap-around sum of every pixel written by the current copy on 'checksum'.
// Without the macro, 'checksum' is tied to zero and no adder is built.
module frame_copy_ctrl #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] length,
    input  logic              hold,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done,
    output logic [15:0]       checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] src_reg;
    logic [ADDR_W-1:0] dst_reg;
    logic [ADDR_W-1:0] len_reg;
    logic [ADDR_W-1:0] index;

    // A start is only honoured while no copy is running.
    logic start_accept;
    assign start_accept = start && ((state == IDLE) || (state == DONE));

    // Copy sequencer: READ presents the pixel's ROM data to the RAM (unless the
    // write port is held), WRITE moves the ROM address on or finishes the copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            src_reg    <= '0;
            dst_reg    <= '0;
            len_reg    <= '0;
            index      <= '0;
            rom_addr   <= '0;
            ram_wraddr <= '0;
            ram_data   <= '0;
            ram_wren   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    ram_wren <= 1'b0;
                    if (start) begin
                        src_reg <= src_base;
                        dst_reg <= dst_base;
                        len_reg <= length;
                        index   <= '0;
                        if (length != '0) begin
                            state    <= READ;
                            rom_addr <= src_base;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (hold) begin
                        ram_wren <= 1'b0;
                    end else begin
                        ram_data   <= rom_data;
                        ram_wraddr <= dst_reg + index;
                        ram_wren   <= 1'b1;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    ram_wren <= 1'b0;
                    if (index == len_reg - ONE) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        index    <= index + ONE;
                        rom_addr <= src_reg + index + ONE;
                        state    <= READ;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ram_wren <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

`ifdef FRAME_COPY_CHECKSUM_EN
    logic [15:0] sum_reg;

    // Running sum of the pixels written by this copy, restarted by each accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_reg <= '0;
        end else if (start_accept) begin
            sum_reg <= '0;
        end else if ((state == READ) && !hold) begin
            sum_reg <= sum_reg + 16'(rom_data);
        end
    end

    assign checksum = sum_reg;
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
    assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_frame_copy_ctrl.sv
// tb_frame_copy_ctrl: directed, table-driven bench for frame_copy_ctrl.
// The ROM is modelled as returning the data for the address register the
// controller loaded on the previous edge. Cycle 0 is the cycle in which start
// is high; with no hold, writes appear in cycles 2,4,..,2N and done in 2N+1.
module tb_frame_copy_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [18:0] src_base;
    logic [18:0] dst_base;
    logic [18:0] length;
    logic        hold;
    logic [18:0] rom_addr;
    logic [7:0]  rom_data;
    logic [18:0] ram_wraddr;
    logic [7:0]  ram_data;
    logic        ram_wren;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    int compared;
    int mismatched;

    // ROM content selection: 0 = data is addr[7:0], 1 = small checksum pattern
    logic romMode;

    frame_copy_ctrl #(.ADDR_W(19), .DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_base   (src_base),
        .dst_base   (dst_base),
        .length     (length),
        .hold       (hold),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .ram_wraddr (ram_wraddr),
        .ram_data   (ram_data),
        .ram_wren   (ram_wren),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] chkRom(input logic [18:0] a);
        case (a)
            19'h20:  return 8'hFF;
            19'h21:  return 8'hFF;
            19'h22:  return 8'h02;
            19'h23:  return 8'h03;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] romModel(input logic mode, input logic [18:0] a);
        return mode ? chkRom(a) : a[7:0];
    endfunction

    assign rom_data = romModel(romMode, rom_addr);

    typedef struct {
        logic [18:0] src;
        logic [18:0] dst;
        logic [18:0] len;
        int          holdFrom;
        int          holdCount;
        int          pulseAt;
        int          limit;
        int          expWrites;
        int          expDone;
        logic [18:0] expFirstAddr;
        logic [7:0]  expFirstData;
        logic [18:0] expLastAddr;
        logic [7:0]  expLastData;
    } vec_t;

    vec_t vecs[8];

    // Observations gathered by applyStimulus
    int          writes;
    int          orderErr;
    int          holdErr;
    int          doneCycle;
    logic        busySeen;
    logic [18:0] firstAddr;
    logic [7:0]  firstData;
    logic [18:0] lastAddr;
    logic [7:0]  lastData;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one copy from cycle 0 until done is seen or the cycle limit expires.
    task automatic applyStimulus(input logic [18:0] src, input logic [18:0] dst,
                                 input logic [18:0] len, input int holdFrom,
                                 input int holdCount, input int pulseAt, input int limit);
        logic        prevHold;
        logic [18:0] expAddr;
        logic [7:0]  expData;
        @(negedge clk);
        src_base  = src;
        dst_base  = dst;
        length    = len;
        start     = 1'b1;
        hold      = 1'b0;
        prevHold  = 1'b0;
        writes    = 0;
        orderErr  = 0;
        holdErr   = 0;
        doneCycle = -1;
        busySeen  = 1'b0;
        firstAddr = '0;
        firstData = '0;
        lastAddr  = '0;
        lastData  = '0;
        for (int c = 1; c <= limit && doneCycle < 0; c++) begin
            @(negedge clk);
            if (ram_wren) begin
                if (prevHold) holdErr++;
                expAddr = dst + 19'(writes);
                expData = romModel(romMode, src + 19'(writes));
                if (ram_wraddr !== expAddr || ram_data !== expData) orderErr++;
                if (writes == 0) begin
                    firstAddr = ram_wraddr;
                    firstData = ram_data;
                end
                lastAddr = ram_wraddr;
                lastData = ram_data;
                writes++;
            end
            if (busy) busySeen = 1'b1;
            if (done) doneCycle = c;
            start = (c == pulseAt);
            if (c == pulseAt) begin
                src_base = 19'h5A5A5;
                dst_base = 19'h12345;
                length   = 19'd3;
            end
            hold     = (c >= holdFrom) && (c < holdFrom + holdCount);
            prevHold = hold;
        end
        start = 1'b0;
        hold  = 1'b0;
    endtask

    initial begin
        int          n;
        int          stray;
        logic [15:0] expChk;

        compared   = 0;
        mismatched = 0;
        romMode    = 1'b0;
        reset      = 1'b1;
        start      = 1'b0;
        hold       = 1'b0;
        src_base   = '0;
        dst_base   = '0;
        length     = '0;

        //            src       dst       len     hF hC pul limit  wr  done   fAddr     fD     lAddr     lD
        vecs[0] = '{19'h0000A, 19'h00010, 19'd1,   0, 0, 0,  20,    1,  3,     19'h00010, 8'h0A, 19'h00010, 8'h0A};
        vecs[1] = '{19'h00010, 19'h00200, 19'd3,   0, 0, 0,  40,    3,  7,     19'h00200, 8'h10, 19'h00202, 8'h12};
        vecs[2] = '{19'h7FFFE, 19'h7FFFF, 19'd4,   0, 0, 0,  40,    4,  9,     19'h7FFFF, 8'hFE, 19'h00002, 8'h01};
        vecs[3] = '{19'h00005, 19'h00006, 19'd0,   0, 0, 0,  20,    0,  1,     19'h00000, 8'h00, 19'h00000, 8'h00};
        vecs[4] = '{19'h00080, 19'h01000, 19'd8,   5, 5, 0,  60,    8,  22,    19'h01000, 8'h80, 19'h01007, 8'h87};
        vecs[5] = '{19'h00090, 19'h02000, 19'd8,   4, 5, 0,  60,    8,  21,    19'h02000, 8'h90, 19'h02007, 8'h97};
        vecs[6] = '{19'h00040, 19'h00100, 19'd6,   0, 0, 6,  60,    6,  13,    19'h00100, 8'h40, 19'h00105, 8'h45};
        vecs[7] = '{19'h00000, 19'h00000, 19'd19200, 0, 0, 0, 40000, 19200, 38401, 19'h00000, 8'h00, 19'h04AFF, 8'hFF};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_rom_addr",   32'(rom_addr),   32'h0);
        checkOutput("reset_ram_wraddr", 32'(ram_wraddr), 32'h0);
        checkOutput("reset_ram_data",   32'(ram_data),   32'h0);
        checkOutput("reset_ram_wren",   32'(ram_wren),   32'h0);
        checkOutput("reset_busy",       32'(busy),       32'h0);
        checkOutput("reset_done",       32'(done),       32'h0);
        checkOutput("reset_checksum",   32'(checksum),   32'h0);
        reset = 1'b0;

        // Table-driven copies
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].holdFrom,
                          vecs[v].holdCount, vecs[v].pulseAt, vecs[v].limit);
            checkOutput($sformatf("v%0d_writes", v),    32'(writes),    32'(vecs[v].expWrites));
            checkOutput($sformatf("v%0d_done_cyc", v),  32'(doneCycle), 32'(vecs[v].expDone));
            checkOutput($sformatf("v%0d_order", v),     32'(orderErr),  32'h0);
            checkOutput($sformatf("v%0d_hold_wren", v), 32'(holdErr),   32'h0);
            if (vecs[v].len == 19'd0) begin
                checkOutput($sformatf("v%0d_busy_seen", v), 32'(busySeen), 32'h0);
            end else begin
                checkOutput($sformatf("v%0d_first_addr", v), 32'(firstAddr), 32'(vecs[v].expFirstAddr));
                checkOutput($sformatf("v%0d_first_data", v), 32'(firstData), 32'(vecs[v].expFirstData));
                checkOutput($sformatf("v%0d_last_addr", v),  32'(lastAddr),  32'(vecs[v].expLastAddr));
                checkOutput($sformatf("v%0d_last_data", v),  32'(lastData),  32'(vecs[v].expLastData));
            end
            repeat (2) @(negedge clk);
            checkOutput($sformatf("v%0d_done_level", v), 32'(done),     32'h1);
            checkOutput($sformatf("v%0d_busy_after", v), 32'(busy),     32'h0);
            checkOutput($sformatf("v%0d_wren_after", v), 32'(ram_wren), 32'h0);
        end

        // Reset asserted in the cycle of the 10th write of a 100-pixel copy
        @(negedge clk);
        src_base = 19'h0;
        dst_base = 19'h300;
        length   = 19'd100;
        start    = 1'b1;
        n        = 0;
        for (int c = 1; c <= 400 && n < 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (ram_wren) n++;
        end
        checkOutput("rst_mid_writes_before", 32'(n), 32'd10);
        checkOutput("rst_mid_ram_data_10th", 32'(ram_data), 32'h09);
        reset = 1'b1;
        start = 1'b1;
        hold  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        hold  = 1'b0;
        checkOutput("rst_mid_rom_addr",   32'(rom_addr),   32'h0);
        checkOutput("rst_mid_ram_wraddr", 32'(ram_wraddr), 32'h0);
        checkOutput("rst_mid_ram_data",   32'(ram_data),   32'h0);
        checkOutput("rst_mid_ram_wren",   32'(ram_wren),   32'h0);
        checkOutput("rst_mid_busy",       32'(busy),       32'h0);
        checkOutput("rst_mid_done",       32'(done),       32'h0);
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (ram_wren || busy || done) stray++;
        end
        checkOutput("rst_mid_quiet", 32'(stray), 32'h0);
        applyStimulus(19'h0, 19'h300, 19'd100, 0, 0, 0, 400);
        checkOutput("rst_restart_writes", 32'(writes),    32'd100);
        checkOutput("rst_restart_done",   32'(doneCycle), 32'd201);
        checkOutput("rst_restart_order",  32'(orderErr),  32'h0);
        checkOutput("rst_restart_last",   32'(lastAddr),  32'h363);

        // Checksum pattern 0xFF,0xFF,0x02,0x03
        romMode = 1'b1;
        applyStimulus(19'h20, 19'h50, 19'd4, 0, 0, 0, 40);
`ifdef FRAME_COPY_CHECKSUM_EN
        expChk = 16'h0203;
`else
        expChk = 16'h0000;
`endif
        checkOutput("chk_writes",    32'(writes),    32'd4);
        checkOutput("chk_order",     32'(orderErr),  32'h0);
        checkOutput("chk_last_data", 32'(lastData),  32'h03);
        checkOutput("chk_checksum",  32'(checksum),  32'(expChk));
        romMode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
